stream_mux_n: RTL and testbench
===============================

// Module: stream_mux_n
// PURPOSE
//  Parametrised N-input, W-bit multiplexer with valid/ready handshakes on
//  every input and a single registered output. It generalises the 4:1
//  bit-select mux to N channels and W bits. It adds two modes: external
//  select, and round-robin arbitration across the valid inputs.
//  It sits between N producer streams and one consumer, such as a shared
//  bus or a serialiser.
// PARAMETERS
//  N      4  number of input channels, N >= 2
//  W      8  data width per channel, in bits
//  MODE   0  0 = external select (sel); 1 = round-robin arbitration
//  SEL_W  $clog2(N) (minimum 1)  width of sel and out_chan
// PORTS
//  clk        in   1        single clock; all state updates on the rising edge
//  rst        in   1        reset, synchronous and active-high
//  in_valid   in   N        bit i high = channel i is offering data
//  in_data    in   N*W      channel i data at in_data[i*W +: W]
//  in_ready   out  N        bit i high = channel i data is taken this cycle
//  sel        in   SEL_W    channel select; used only when MODE = 0
//  out_valid  out  1        output register holds data
//  out_data   out  W        registered data
//  out_chan   out  SEL_W    index of the channel that supplied out_data
//  out_ready  in   1        consumer accepts out_data this cycle
//  sel_err    out  1        registered one-cycle pulse: sel >= N (MODE 0 only)
// BEHAVIOUR
//  Reset (rst = 1 at an edge):
//   - out_valid, out_data, out_chan, sel_err and the RR pointer ptr all go to 0.
//   - Any data held in the output register is discarded.
//   - in_ready is forced to 0 while rst = 1.
//  Load enable:
//   - load = !out_valid || out_ready (combinational).
//  Grant (combinational):
//   - MODE 0: grant = sel when sel < N and in_valid[sel] = 1; otherwise no grant.
//   - MODE 1: first i with in_valid[i] = 1, searching ptr, ptr+1, ..., N-1,
//     then 0, ..., ptr-1 (modulo N); no grant if in_valid = 0.
//  Ready and transfer:
//   - in_ready[i] = load && grant valid && grant == i.
//   - At most one bit of in_ready is high per cycle.
//   - An input transfer occurs when in_valid[i] && in_ready[i].
//  On an input transfer at an edge:
//   - out_data <= channel data; out_chan <= i; out_valid <= 1.
//   - MODE 1: ptr <= (i == N-1) ? 0 : i+1.
//  Otherwise, out_valid <= out_valid && !out_ready; out_data and out_chan hold.
//  Latency and throughput:
//   - Latency from input transfer to out_valid is 1 cycle.
//   - Full throughput: when out_valid && out_ready and a grant both hold in
//     the same cycle, the new data replaces the old one with no bubble.
//  Backpressure:
//   - While out_valid && !out_ready: out_data and out_chan stay stable and
//     all in_ready bits are 0.
//  Select handling (MODE 0):
//   - sel may change on any cycle; it is sampled only in a cycle that
//     transfers.
//   - sel >= N: no transfer occurs.
//   - sel >= N while load = 1 at an edge: sel_err <= 1 for exactly one cycle.
//   - MODE 1: sel is ignored and sel_err is held at 0.
//  Round-robin wrap:
//   - The pointer wraps from N-1 to 0.
//   - Channels that are not valid are skipped with no lost cycle.
//  Fairness:
//   - MODE 1 with all inputs valid and out_ready held at 1: each channel is
//     served once every N cycles.
//  Data width:
//   - Data is passed through unchanged; no arithmetic is applied.
// TESTING
//  T1 MODE0, N=4, W=8: sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1
//     -> in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=A5, out_chan=2.
//  T2 Backpressure: after T1, hold out_ready=0 for 3 cycles with ch2 valid
//     -> out_data=A5 stable; in_ready=0; after out_ready=1, next data arrives with no bubble.
//  T3 MODE1: all 4 inputs valid, ch i data = 8'h10+i, out_ready=1 from reset
//     -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles.
//  T4 MODE1: in_valid=4'b1010 after reset
//     -> out_chan sequence 1,3,1,3; no idle cycles between transfers.
//  T5 MODE0, N=3, SEL_W=2: sel=3, all inputs valid, out_ready=1
//     -> in_ready=0; sel_err high one cycle per such cycle; out_valid falls to 0.
//  T6 Reset mid-operation: rst=1 for 1 cycle while out_valid=1 and ptr=2
//     -> next cycle out_valid=0, out_data=0; the next grant starts at ch0.

Source files
------------

// File: rtl/stream_mux_n.sv
// N-input, W-bit stream multiplexer with a single registered output stage.
// MODE 0 picks the channel named by sel; MODE 1 round-robins over valid inputs.
`timescale 1ns/1ps
module stream_mux_n #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int MODE  = 0,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*W-1:0]     in_data,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [SEL_W-1:0]   out_chan,
  input  logic               out_ready,
  output logic               sel_err
);

  logic               r_out_valid;
  logic [W-1:0]       r_out_data;
  logic [SEL_W-1:0]   r_out_chan;
  logic [SEL_W-1:0]   r_ptr;
  logic               r_sel_err;

  logic               w_load;
  logic               w_sel_ok;
  logic               w_gnt_vld;
  logic [SEL_W-1:0]   w_gnt;
  logic [W-1:0]       w_gnt_data;
  logic [N-1:0]       w_ready;
  logic               w_xfer;
  logic [2*N-1:0]     w_dbl;
  logic [N-1:0]       w_rot;

  // Handshake: a channel transfers on an edge where in_valid[i] && in_ready[i];
  // the consumer takes out_data on an edge where out_valid && out_ready.
  assign w_load   = !r_out_valid || out_ready;
  assign w_sel_ok = (int'(sel) < N);

  // Rotate the valid vector so bit 0 corresponds to the channel at ptr.
  assign w_dbl = {in_valid, in_valid} >> r_ptr;
  assign w_rot = w_dbl[N-1:0];

  always_comb begin
    int s;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    s         = 0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = SEL_W'(i);
        end
      end
    end else begin
      // Scan downward so the lowest rotated offset wins.
      for (int f = N - 1; f >= 0; f--) begin
        if (w_rot[f]) begin
          s = int'(r_ptr) + f;
          if (s >= N) s = s - N;
          w_gnt_vld = 1'b1;
          w_gnt     = SEL_W'(s);
        end
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt == SEL_W'(i)) w_gnt_data = in_data[i*W +: W];
    end
  end

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < N; i++) begin
      w_ready[i] = !rst && w_load && w_gnt_vld && (w_gnt == SEL_W'(i));
    end
  end

  assign w_xfer = |(in_valid & w_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_ptr       <= '0;
      r_sel_err   <= 1'b0;
    end else begin
      r_sel_err <= (MODE == 0) && w_load && !w_sel_ok;
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt_data;
        r_out_chan  <= w_gnt;
        if (MODE == 1) begin
          r_ptr <= (int'(w_gnt) == N - 1) ? '0 : SEL_W'(int'(w_gnt) + 1);
        end
      end else begin
        r_out_valid <= r_out_valid && !out_ready;
      end
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: three instances (MODE0 N=4, MODE1 N=4, MODE0 N=3)
// checked every cycle against a transaction-level model plus literal vectors.
`timescale 1ns/1ps
module tb_stream_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, ordy0, ov0, err0;
  logic [3:0] v0, rdy0;
  logic [31:0] d0;
  logic [1:0] sel0, oc0;
  logic [7:0] od0;

  logic rst1, ordy1, ov1, err1;
  logic [3:0] v1, rdy1;
  logic [31:0] d1;
  logic [1:0] sel1, oc1;
  logic [7:0] od1;

  logic rst2, ordy2, ov2, err2;
  logic [2:0] v2, rdy2;
  logic [23:0] d2;
  logic [1:0] sel2, oc2;
  logic [7:0] od2;

  logic done0 = 1'b0, done1 = 1'b0, done2 = 1'b0;
  logic armed = 1'b0;
  int n_err = 0;
  int n_checks = 0;

  stream_mux_n #(.N(4), .W(8), .MODE(0)) u0 (
    .clk(clk), .rst(rst0), .in_valid(v0), .in_data(d0), .in_ready(rdy0),
    .sel(sel0), .out_valid(ov0), .out_data(od0), .out_chan(oc0),
    .out_ready(ordy0), .sel_err(err0));

  stream_mux_n #(.N(4), .W(8), .MODE(1)) u1 (
    .clk(clk), .rst(rst1), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
    .sel(sel1), .out_valid(ov1), .out_data(od1), .out_chan(oc1),
    .out_ready(ordy1), .sel_err(err1));

  stream_mux_n #(.N(3), .W(8), .MODE(0), .SEL_W(2)) u2 (
    .clk(clk), .rst(rst2), .in_valid(v2), .in_data(d2), .in_ready(rdy2),
    .sel(sel2), .out_valid(ov2), .out_data(od2), .out_chan(oc2),
    .out_ready(ordy2), .sel_err(err2));

  typedef struct {
    logic       v;
    logic [7:0] d;
    int         chan;
    int         ptr;
    logic       err;
  } mstate_t;

  mstate_t ms[3];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d actual=%h required=%h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Channel that wins this cycle, or -1 when none does.
  function automatic int grant(input int n, input int mode, input logic [3:0] v, input int sel, input int ptr);
    if (mode == 0) begin
      if (sel < n && v[sel]) return sel;
      return -1;
    end
    for (int k = 0; k < n; k++) begin
      int c;
      c = (ptr + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic step(input int k, input int n, input int mode, input logic rst,
                      input logic [3:0] v, input logic [31:0] d, input int sel,
                      input logic ordy, input logic [3:0] a_rdy, input logic a_ov,
                      input logic [7:0] a_od, input int a_oc, input logic a_err);
    int g;
    logic load;
    logic [3:0] e_rdy;
    g     = grant(n, mode, v, sel, ms[k].ptr);
    load  = !ms[k].v || ordy;
    e_rdy = (!rst && load && g >= 0) ? 4'(1 << g) : 4'h0;
    chk("m_rdy", k, 32'(a_rdy), 32'(e_rdy));
    chk("m_ov", k, 32'(a_ov), 32'(ms[k].v));
    chk("m_od", k, 32'(a_od), 32'(ms[k].d));
    chk("m_chan", k, a_oc, ms[k].chan);
    chk("m_err", k, 32'(a_err), 32'(ms[k].err));
    if (rst) begin
      ms[k] = '{1'b0, 8'h00, 0, 0, 1'b0};
    end else begin
      ms[k].err = (mode == 0) && load && (sel >= n);
      if (load && g >= 0) begin
        ms[k].v    = 1'b1;
        ms[k].d    = d[g*8 +: 8];
        ms[k].chan = g;
        if (mode == 1) ms[k].ptr = (g + 1) % n;
      end else begin
        ms[k].v = ms[k].v && !ordy;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) ms[k] = '{1'b0, 8'h00, 0, 0, 1'b0};
    @(posedge clk);
    #1 armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      step(0, 4, 0, rst0, v0, d0, int'(sel0), ordy0, rdy0, ov0, od0, int'(oc0), err0);
      step(1, 4, 1, rst1, v1, d1, int'(sel1), ordy1, rdy1, ov1, od1, int'(oc1), err1);
      step(2, 3, 0, rst2, {1'b0, v2}, {8'h00, d2}, int'(sel2), ordy2, {1'b0, rdy2},
           ov2, od2, int'(oc2), err2);
    end
  end

  initial begin : stim0
    rst0 = 1'b1; v0 = 4'b0100; sel0 = 2'd2; d0 = 32'h00A5_0000; ordy0 = 1'b1;
    cyc(); cyc();
    chk("rst_ov", 0, 32'(ov0), 32'h0);
    chk("rst_od", 0, 32'(od0), 32'h0);
    chk("rst_rdy_forced", 0, 32'(rdy0), 32'h0);
    chk("rst_err", 0, 32'(err0), 32'h0);
    rst0 = 1'b0;
    #1 chk("t1_rdy", 0, 32'(rdy0), 32'h4);
    cyc();
    ordy0 = 1'b0; d0 = 32'h005A_0000;
    #1;
    chk("t1_ov", 0, 32'(ov0), 32'h1);
    chk("t1_od", 0, 32'(od0), 32'hA5);
    chk("t1_chan", 0, 32'(oc0), 32'h2);
    chk("t2_rdy", 0, 32'(rdy0), 32'h0);
    repeat (3) begin
      cyc();
      chk("t2_hold_od", 0, 32'(od0), 32'hA5);
      chk("t2_hold_rdy", 0, 32'(rdy0), 32'h0);
    end
    ordy0 = 1'b1;
    #1 chk("t2_release_rdy", 0, 32'(rdy0), 32'h4);
    cyc();
    chk("t2_nobubble_ov", 0, 32'(ov0), 32'h1);
    chk("t2_nobubble_od", 0, 32'(od0), 32'h5A);
    sel0 = 2'd1;
    cyc();
    chk("sel_idle_ov", 0, 32'(ov0), 32'h0);
    chk("sel_idle_err", 0, 32'(err0), 32'h0);
    sel0 = 2'd3; v0 = 4'b1000; d0 = 32'hC300_0000;
    #1 chk("sel3_rdy", 0, 32'(rdy0), 32'h8);
    cyc();
    chk("sel3_od", 0, 32'(od0), 32'hC3);
    chk("sel3_chan", 0, 32'(oc0), 32'h3);
    v0 = 4'b0000;
    cyc(); cyc();
    done0 = 1'b1;
  end

  initial begin : stim1
    int seq3[6];
    int seq4[4];
    seq3 = '{0, 1, 2, 3, 0, 1};
    seq4 = '{1, 3, 1, 3};
    rst1 = 1'b1; v1 = 4'hF; d1 = 32'h1312_1110; ordy1 = 1'b1; sel1 = 2'd3;
    cyc(); cyc();
    rst1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t3_ov", 1, 32'(ov1), 32'h1);
      chk("t3_chan", 1, 32'(oc1), 32'(seq3[i]));
      chk("t3_data", 1, 32'(od1), 32'h10 + 32'(seq3[i]));
      chk("t3_err_held", 1, 32'(err1), 32'h0);
    end
    rst1 = 1'b1;
    cyc();
    rst1 = 1'b0;
    #1;
    chk("t6_ov", 1, 32'(ov1), 32'h0);
    chk("t6_od", 1, 32'(od1), 32'h0);
    cyc();
    chk("t6_chan", 1, 32'(oc1), 32'h0);
    chk("t6_data", 1, 32'(od1), 32'h10);
    rst1 = 1'b1;
    cyc();
    rst1 = 1'b0; v1 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t4_ov", 1, 32'(ov1), 32'h1);
      chk("t4_chan", 1, 32'(oc1), 32'(seq4[i]));
    end
    ordy1 = 1'b0;
    cyc(); cyc();
    ordy1 = 1'b1; v1 = 4'b0001;
    cyc(); cyc(); cyc();
    v1 = 4'b0000;
    cyc(); cyc();
    chk("drain_ov", 1, 32'(ov1), 32'h0);
    done1 = 1'b1;
  end

  initial begin : stim2
    rst2 = 1'b1; v2 = 3'b111; d2 = 24'h22_2120; sel2 = 2'd1; ordy2 = 1'b1;
    cyc(); cyc();
    rst2 = 1'b0;
    cyc();
    chk("n3_ov", 2, 32'(ov2), 32'h1);
    chk("n3_chan", 2, 32'(oc2), 32'h1);
    chk("n3_od", 2, 32'(od2), 32'h21);
    sel2 = 2'd3;
    #1 chk("t5_rdy", 2, 32'(rdy2), 32'h0);
    cyc();
    chk("t5_err", 2, 32'(err2), 32'h1);
    chk("t5_ov_falls", 2, 32'(ov2), 32'h0);
    cyc();
    chk("t5_err_again", 2, 32'(err2), 32'h1);
    sel2 = 2'd0;
    cyc();
    chk("t5_err_clear", 2, 32'(err2), 32'h0);
    chk("t5_od", 2, 32'(od2), 32'h20);
    chk("t5_chan", 2, 32'(oc2), 32'h0);
    ordy2 = 1'b0; sel2 = 2'd3;
    cyc();
    chk("t5_noload_err", 2, 32'(err2), 32'h0);
    chk("t5_noload_ov", 2, 32'(ov2), 32'h1);
    ordy2 = 1'b1;
    cyc();
    chk("t5_load_err", 2, 32'(err2), 32'h1);
    chk("t5_load_ov", 2, 32'(ov2), 32'h0);
    sel2 = 2'd2;
    cyc();
    chk("n3_ch2_od", 2, 32'(od2), 32'h22);
    chk("n3_ch2_chan", 2, 32'(oc2), 32'h2);
    done2 = 1'b1;
  end

  initial begin : report
    for (int i = 0; i < 5000; i++) begin
      if (done0 && done1 && done2) break;
      @(posedge clk);
    end
    chk("stimulus_done", 0, 32'({done0, done1, done2}), 32'h7);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
